// File: rtl/decoder38_hold_if.sv
// -----------------------------------------------------------------------------
// decoder38_hold_if
// Purpose : bundles the code/control inputs and the display outputs of the
//           registered 3-to-8 decoder into one interface.
// Signals :
//   en         decoder enable
//   code_valid code qualifies this cycle
//   code[3:0]  0-7 legal index, 4'b1111 = no input, 8-14 illegal
//   err_clr    single-cycle clear of the sticky error flag
//   y[7:0]     one-hot displayed index (0 when nothing shown)
//   y_valid    high while an index is shown or held
//   change     one-cycle pulse when the displayed index changes/first appears
//   err        sticky illegal-code flag
//   HEX[6:0]   active-low 7-segment pattern of the displayed index
// Modports: master = code source / display consumer, slave = decoder.
// -----------------------------------------------------------------------------
interface decoder38_hold_if;
    logic       en;
    logic       code_valid;
    logic [3:0] code;
    logic       err_clr;
    logic [7:0] y;
    logic       y_valid;
    logic       change;
    logic       err;
    logic [6:0] HEX;

    modport master (
        output en, code_valid, code, err_clr,
        input  y, y_valid, change, err, HEX
    );

    modport slave (
        input  en, code_valid, code, err_clr,
        output y, y_valid, change, err, HEX
    );
endinterface

// File: rtl/decoder38_hold.sv
// -----------------------------------------------------------------------------
// decoder38_hold
// Purpose : registered 3-to-8 decoder for the priority-encoder code. Shows the
//           received index on a one-hot LED bank and an active-low 7-seg digit,
//           keeps the last index displayed for HOLD_CYCLES cycles after the
//           input goes idle, and flags out-of-range codes with a sticky error.
// Ports   :
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    decoder38_hold_if.slave (en, code_valid, code, err_clr in;
//          y, y_valid, change, err, HEX out -- all outputs registered)
// Parameters:
//   HOLD_CYCLES  cycles the last index stays displayed after idle (0 = none)
//   BLINK_DIV    half-period of the hold blink in cycles (>= 1)
// Build option:
//   DEC38_BLINK_EN  when defined, y/HEX blink during HOLD (phase starts ON);
//                   when undefined, HOLD is steady and no blink counter exists.
// -----------------------------------------------------------------------------
module decoder38_hold #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_DIV   = 12_500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder38_hold_if.slave  bus
);

    localparam int               HOLD_W    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
    localparam logic [6:0]        HEX_BLANK = 7'b1111111;

    // Reject parameter values the counters cannot represent.
    if (HOLD_CYCLES < 0) begin : g_bad_hold
        $error("decoder38_hold: HOLD_CYCLES must be >= 0");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("decoder38_hold: BLINK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [7:0]        r_y;
    logic [6:0]        r_hex;
    logic              r_y_valid;
    logic              r_change;
    logic              r_err;

`ifdef DEC38_BLINK_EN
    localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
`endif

    logic w_legal;
    logic w_illegal;

    // One-hot LED pattern for a 3-bit index.
    function automatic logic [7:0] f_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // Active-low 7-seg pattern (gfedcba) for digits 0-7.
    function automatic logic [6:0] f_seg(input logic [2:0] idx);
        logic [6:0] seg;
        case (idx)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Input qualification; 4'b1111 is a normal idle and never an error.
    assign w_legal   = bus.en & bus.code_valid & ~bus.code[3];
    assign w_illegal = bus.en & bus.code_valid & bus.code[3] & (bus.code != 4'b1111);

    // Decoder FSM, hold timer, optional blink and sticky error, all registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_hold_cnt <= '0;
            r_y        <= 8'h00;
            r_hex      <= HEX_BLANK;
            r_y_valid  <= 1'b0;
            r_change   <= 1'b0;
            r_err      <= 1'b0;
`ifdef DEC38_BLINK_EN
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
`endif
        end else begin
            // Set beats clear when both happen in the same cycle.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            // Defaults: no pulse, timers cleared; only the HOLD paths override.
            r_change   <= 1'b0;
            r_hold_cnt <= '0;
`ifdef DEC38_BLINK_EN
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
`endif

            if (!bus.en) begin
                r_state   <= ST_IDLE;
                r_y       <= 8'h00;
                r_hex     <= HEX_BLANK;
                r_y_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_legal) begin
                            r_state   <= ST_SHOW;
                            r_idx     <= bus.code[2:0];
                            r_y       <= f_onehot(bus.code[2:0]);
                            r_hex     <= f_seg(bus.code[2:0]);
                            r_y_valid <= 1'b1;
                            r_change  <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_y       <= 8'h00;
                            r_hex     <= HEX_BLANK;
                            r_y_valid <= 1'b0;
                        end
                    end
                    ST_SHOW, ST_HOLD: begin
                        if (w_legal) begin
                            // Re-showing the held index is not a change.
                            r_state   <= ST_SHOW;
                            r_idx     <= bus.code[2:0];
                            r_y       <= f_onehot(bus.code[2:0]);
                            r_hex     <= f_seg(bus.code[2:0]);
                            r_y_valid <= 1'b1;
                            r_change  <= (bus.code[2:0] != r_idx);
                        end else if (r_state == ST_SHOW) begin
                            if (HOLD_CYCLES == 0) begin
                                r_state   <= ST_IDLE;
                                r_y       <= 8'h00;
                                r_hex     <= HEX_BLANK;
                                r_y_valid <= 1'b0;
                            end else begin
                                // y/HEX keep the SHOW value, which is also the ON blink phase.
                                r_state    <= ST_HOLD;
                                r_hold_cnt <= HOLD_LOAD;
                                r_y_valid  <= 1'b1;
                            end
                        end else if (r_hold_cnt == '0) begin
                            r_state   <= ST_IDLE;
                            r_y       <= 8'h00;
                            r_hex     <= HEX_BLANK;
                            r_y_valid <= 1'b0;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                            r_y_valid  <= 1'b1;
`ifdef DEC38_BLINK_EN
                            // Toggle the phase every BLINK_DIV cycles spent in HOLD.
                            if (r_blink_cnt == BLINK_LAST) begin
                                r_blink_cnt <= '0;
                                r_blink_on  <= ~r_blink_on;
                                if (r_blink_on) begin
                                    r_y   <= 8'h00;
                                    r_hex <= HEX_BLANK;
                                end else begin
                                    r_y   <= f_onehot(r_idx);
                                    r_hex <= f_seg(r_idx);
                                end
                            end else begin
                                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                                r_blink_on  <= r_blink_on;
                            end
`endif
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_y       <= 8'h00;
                        r_hex     <= HEX_BLANK;
                        r_y_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.y       = r_y;
    assign bus.HEX     = r_hex;
    assign bus.y_valid = r_y_valid;
    assign bus.change  = r_change;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_decoder38_hold.sv
// -----------------------------------------------------------------------------
// tb_decoder38_hold
// Directed stimulus for decoder38_hold (HOLD_CYCLES=4, BLINK_DIV=2). A model
// derives the expected outputs from the run length of idle samples since the
// last legal code; a negedge process compares every output each cycle, and a
// few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_decoder38_hold;
    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    decoder38_hold_if bus();

    decoder38_hold #(.HOLD_CYCLES(HOLD), .BLINK_DIV(BLINK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] seg_tab [8];
    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    end

    // Model state: last index, whether anything is displayable, idle run length.
    logic       started;
    logic       m_active;
    int         m_run;
    logic [2:0] m_idx;
    logic [7:0] e_y;
    logic [6:0] e_hex;
    logic       e_v;
    logic       e_chg;
    logic       e_err;

    // Reference model: outputs one cycle after the sampled inputs.
    always @(posedge clk) begin
        logic on;
        started <= 1'b1;
        if (!rst_n) begin
            m_active <= 1'b0; m_run <= 0; m_idx <= 3'd0;
            e_y <= 8'h00; e_hex <= 7'h7F; e_v <= 1'b0; e_chg <= 1'b0; e_err <= 1'b0;
        end else begin
            if (bus.en && bus.code_valid && bus.code >= 4'd8 && bus.code <= 4'd14) e_err <= 1'b1;
            else if (bus.err_clr) e_err <= 1'b0;

            if (!bus.en) begin
                m_active <= 1'b0;
                e_y <= 8'h00; e_hex <= 7'h7F; e_v <= 1'b0; e_chg <= 1'b0;
            end else if (bus.code_valid && bus.code < 4'd8) begin
                e_y   <= 8'(1 << bus.code);
                e_hex <= seg_tab[bus.code[2:0]];
                e_v   <= 1'b1;
                e_chg <= !e_v || (bus.code[2:0] != m_idx);
                m_idx <= bus.code[2:0];
                m_active <= 1'b1;
                m_run <= 0;
            end else if (m_active && (m_run + 1) <= HOLD) begin
                m_run <= m_run + 1;
`ifdef DEC38_BLINK_EN
                on = ((m_run / BLINK) % 2) == 0;
`else
                on = 1'b1;
`endif
                e_y   <= on ? 8'(1 << m_idx) : 8'h00;
                e_hex <= on ? seg_tab[m_idx] : 7'h7F;
                e_v   <= 1'b1;
                e_chg <= 1'b0;
            end else begin
                m_active <= 1'b0;
                e_y <= 8'h00; e_hex <= 7'h7F; e_v <= 1'b0; e_chg <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_y",       32'(bus.y),       32'(e_y));
            chk("model_hex",     32'(bus.HEX),     32'(e_hex));
            chk("model_y_valid", 32'(bus.y_valid), 32'(e_v));
            chk("model_change",  32'(bus.change),  32'(e_chg));
            chk("model_err",     32'(bus.err),     32'(e_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic cv, input logic [3:0] code, input logic clr);
        bus.en = en; bus.code_valid = cv; bus.code = code; bus.err_clr = clr;
    endtask

    initial begin
        total = 0; bad = 0; started = 1'b0;
        rst_n = 1'b0;
        // 1. reset with a code pending, then first appearance
        drive(1'b1, 1'b1, 4'd5, 1'b0);
        step(2);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_hex", 32'(bus.HEX), 32'h7F);
        chk("rst_err", 32'(bus.err), 32'h0);
        rst_n = 1'b1;
        step(1);
        chk("t1_y", 32'(bus.y), 32'h20);
        chk("t1_hex", 32'(bus.HEX), 32'b0010010);
        chk("t1_change", 32'(bus.change), 32'h1);
        step(1);
        chk("t1_change_once", 32'(bus.change), 32'h0);

        // 2. show 3 then idle: four cycles of hold, then blank
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        step(1);
        drive(1'b1, 1'b0, 4'd3, 1'b0);
        step(4);
        chk("t2_hold_valid", 32'(bus.y_valid), 32'h1);
`ifndef DEC38_BLINK_EN
        chk("t2_hold_y", 32'(bus.y), 32'h08);
`endif
        step(1);
        chk("t2_end_y", 32'(bus.y), 32'h0);
        chk("t2_end_valid", 32'(bus.y_valid), 32'h0);
        chk("t2_end_hex", 32'(bus.HEX), 32'h7F);

        // 3. re-show same index from HOLD (no pulse), then new index
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        step(1);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        step(2);
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        step(1);
        chk("t3_same_y", 32'(bus.y), 32'h08);
        chk("t3_same_change", 32'(bus.change), 32'h0);
        drive(1'b1, 1'b1, 4'd6, 1'b0);
        step(1);
        chk("t3_new_y", 32'(bus.y), 32'h40);
        chk("t3_new_change", 32'(bus.change), 32'h1);
        step(1);

        // 4. sticky error, set-wins, clear, 4'b1111 is plain idle
        drive(1'b1, 1'b1, 4'b1010, 1'b0);
        step(1);
        chk("t4_err_set", 32'(bus.err), 32'h1);
        drive(1'b1, 1'b1, 4'd12, 1'b1);
        step(1);
        chk("t4_set_wins", 32'(bus.err), 32'h1);
        drive(1'b1, 1'b0, 4'd0, 1'b1);
        step(1);
        chk("t4_clr", 32'(bus.err), 32'h0);
        drive(1'b1, 1'b1, 4'b1111, 1'b0);
        step(3);
        chk("t4_f_no_err", 32'(bus.err), 32'h0);
        drive(1'b0, 1'b1, 4'd9, 1'b0);
        step(1);
        chk("t4_en0_no_err", 32'(bus.err), 32'h0);

        // 5. disable while showing 7: immediate blank, no hold
        drive(1'b1, 1'b1, 4'd7, 1'b0);
        step(1);
        chk("t5_y", 32'(bus.y), 32'h80);
        drive(1'b0, 1'b1, 4'd7, 1'b0);
        step(1);
        chk("t5_off_y", 32'(bus.y), 32'h0);
        chk("t5_off_valid", 32'(bus.y_valid), 32'h0);
        chk("t5_off_hex", 32'(bus.HEX), 32'h7F);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        step(1);
        chk("t5_no_hold", 32'(bus.y_valid), 32'h0);

        // reset in the middle of HOLD leaves nothing behind
        drive(1'b1, 1'b1, 4'd1, 1'b0);
        step(1);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        step(1);
        rst_n = 1'b0;
        step(1);
        chk("rst_hold_valid", 32'(bus.y_valid), 32'h0);
        rst_n = 1'b1;
        step(2);
        chk("rst_hold_residue", 32'(bus.y_valid), 32'h0);

        // 6. hold pattern of index 2 (steady or blinking)
        drive(1'b1, 1'b1, 4'd2, 1'b0);
        step(1);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        step(1);
        chk("t6_h1", 32'(bus.y), 32'h04);
        step(1);
        chk("t6_h2", 32'(bus.y), 32'h04);
        step(1);
`ifdef DEC38_BLINK_EN
        chk("t6_h3", 32'(bus.y), 32'h00);
        chk("t6_h3_hex", 32'(bus.HEX), 32'h7F);
`else
        chk("t6_h3", 32'(bus.y), 32'h04);
`endif
        chk("t6_h3_valid", 32'(bus.y_valid), 32'h1);
        step(1);
        step(1);
        chk("t6_idle", 32'(bus.y_valid), 32'h0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
